// File: rtl/pau_arbiter.sv
// pau_arbiter: two-requester round-robin front end for a shared posit arithmetic unit.
// Accepts one operation at a time, waits for the datapath (with a minimum settle window
// and an abort timeout), then holds the response until the consumer takes it.
module pau_arbiter #(
   parameter int unsigned PAU_N       = 32,
   parameter int unsigned WAIT_MIN    = 4,
   parameter int unsigned TIMEOUT     = 255,
   parameter int unsigned COUNTER_LEN = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [1:0]       req0_op,
   input  logic [1:0]       req1_op,
   input  logic [PAU_N-1:0] req0_a,
   input  logic [PAU_N-1:0] req0_b,
   input  logic [PAU_N-1:0] req1_a,
   input  logic [PAU_N-1:0] req1_b,
   output logic             pau_start,
   output logic [1:0]       pau_op,
   output logic [PAU_N-1:0] pau_a,
   output logic [PAU_N-1:0] pau_b,
   input  logic             pau_done,
   input  logic [PAU_N-1:0] pau_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [PAU_N-1:0] rsp_data,
   output logic             rsp_err,
   output logic             busy
);

   localparam logic [COUNTER_LEN-1:0] WaitMinCnt = COUNTER_LEN'(WAIT_MIN);
   localparam logic [COUNTER_LEN-1:0] TimeoutCnt = COUNTER_LEN'(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StRun, StResp} state_e;

   state_e                 state;
   logic [COUNTER_LEN-1:0] count;
   logic                   last_grant;
   logic                   grant_id;
   logic                   grant_any;
   logic                   transfer;
   logic                   done_ok;
   logic                   timed_out;

   // Round-robin grant: on a tie the requester not served last wins.
   always_comb begin
      grant_any = |req_valid;
      if (req_valid == 2'b11) begin
         grant_id = ~last_grant;
      end else begin
         grant_id = req_valid[1];
      end
      req_ready = 2'b00;
      // Gating with rst keeps req_ready low for the whole reset pulse.
      if ((state == StIdle) && !rst && grant_any) begin
         req_ready = {grant_id, ~grant_id};
      end
      transfer = |(req_valid & req_ready);
   end

   // Completion qualifiers; done before the settle window is ignored.
   always_comb begin
      done_ok   = pau_done && (count >= WaitMinCnt);
      timed_out = (count == TimeoutCnt);
   end

   // Control FSM with registered outputs and captured operation/response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= StIdle;
         count      <= '0;
         last_grant <= 1'b1;
         pau_op     <= 2'b00;
         pau_a      <= '0;
         pau_b      <= '0;
         rsp_data   <= '0;
         rsp_id     <= 1'b0;
         rsp_err    <= 1'b0;
         pau_start  <= 1'b0;
         rsp_valid  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (transfer) begin
                  pau_op     <= grant_id ? req1_op : req0_op;
                  pau_a      <= grant_id ? req1_a : req0_a;
                  pau_b      <= grant_id ? req1_b : req0_b;
                  rsp_id     <= grant_id;
                  last_grant <= grant_id;
                  count      <= '0;
                  pau_start  <= 1'b1;
                  busy       <= 1'b1;
                  state      <= StRun;
               end
            end
            StRun: begin
               if (count != TimeoutCnt) begin
                  count <= count + 1'b1;
               end
               // A qualified done takes priority over a simultaneous timeout.
               if (done_ok) begin
                  rsp_data  <= pau_result;
                  rsp_err   <= 1'b0;
                  pau_start <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= StResp;
               end else if (timed_out) begin
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  pau_start <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= StResp;
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= StIdle;
               end
            end
            default: begin
               pau_start <= 1'b0;
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pau_arbiter.sv
// Self-checking bench for pau_arbiter with a behavioural datapath stub and a response
// scoreboard.
module tb_pau_arbiter;

   localparam int RspLimit = 400;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_ready;
   logic [1:0]  req0_op = 2'b00;
   logic [1:0]  req1_op = 2'b00;
   logic [31:0] req0_a = '0;
   logic [31:0] req0_b = '0;
   logic [31:0] req1_a = '0;
   logic [31:0] req1_b = '0;
   logic        pau_start;
   logic [1:0]  pau_op;
   logic [31:0] pau_a;
   logic [31:0] pau_b;
   logic        pau_done = 1'b0;
   logic [31:0] pau_result = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic        rsp_id;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        busy;

   typedef struct {
      logic        id;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   // Datapath stub controls.
   int          run_cyc = 0;
   int          last_run_len = 0;
   int          stub_delay = 5;
   bit          stub_never = 1'b0;
   int          stub_mode = 2;   // 0 fixed, 1 ramp, 2 a^b
   logic [31:0] stub_fixed = '0;

   pau_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req0_op    (req0_op),
      .req1_op    (req1_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .pau_start  (pau_start),
      .pau_op     (pau_op),
      .pau_a      (pau_a),
      .pau_b      (pau_b),
      .pau_done   (pau_done),
      .pau_result (pau_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Stub: run_cyc is the 1-based RUN cycle number, i.e. DUT counter + 1.
   always @(posedge clk) begin
      #1;
      if (pau_start === 1'b1) begin
         run_cyc = run_cyc + 1;
      end else begin
         if (run_cyc != 0) last_run_len = run_cyc;
         run_cyc = 0;
      end
      pau_done = (pau_start === 1'b1) && !stub_never && (run_cyc >= stub_delay);
      case (stub_mode)
         0:       pau_result = stub_fixed;
         1:       pau_result = 32'h100 + 32'(run_cyc);
         default: pau_result = pau_a ^ pau_b;
      endcase
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic issue(input bit id, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] data, input logic err);
      exp_t e;
      int   n;
      if (id) begin
         req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_op = op; req0_a = a; req0_b = b;
      end
      req_valid[id] = 1'b1;
      #1;
      n = 0;
      while (req_ready[id] !== 1'b1 && n < RspLimit) begin
         @(negedge clk);
         #1;
         n++;
      end
      total++;
      if (req_ready !== (id ? 2'b10 : 2'b01)) begin
         bad++;
         $display("FAIL issue_grant id=%0d: req_ready got %b want %b", id, req_ready,
                  id ? 2'b10 : 2'b01);
      end
      e.id = id; e.op = op; e.a = a; e.b = b; e.data = data; e.err = err;
      sb.push_back(e);
      @(negedge clk);
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_rsp(input string name, input int limit);
      exp_t e;
      int   n;
      n = 0;
      @(negedge clk);
      while (rsp_valid !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (rsp_valid !== 1'b1) begin
         bad++;
         $display("FAIL %s rsp_valid timeout: got %b want 1", name, rsp_valid);
         return;
      end
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL %s unexpected response: got id %0d want none", name, rsp_id);
         return;
      end
      e = sb.pop_front();
      total++;
      if (rsp_id !== e.id) begin
         bad++;
         $display("FAIL %s rsp_id: got %0d want %0d", name, rsp_id, e.id);
      end
      total++;
      if (rsp_data !== e.data) begin
         bad++;
         $display("FAIL %s rsp_data: got %h want %h", name, rsp_data, e.data);
      end
      total++;
      if (rsp_err !== e.err) begin
         bad++;
         $display("FAIL %s rsp_err: got %b want %b", name, rsp_err, e.err);
      end
      total++;
      if (pau_op !== e.op || pau_a !== e.a || pau_b !== e.b) begin
         bad++;
         $display("FAIL %s captured op/a/b: got %b %h %h want %b %h %h", name, pau_op,
                  pau_a, pau_b, e.op, e.a, e.b);
      end
   endtask

   task automatic test_reset();
      req_valid = 2'b11;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (req_ready !== 2'b00) begin
         bad++; $display("FAIL reset req_ready: got %b want 00", req_ready);
      end
      total++;
      if (pau_start !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset ctrl: got start=%b rsp_valid=%b busy=%b want 0 0 0",
                  pau_start, rsp_valid, busy);
      end
      total++;
      if (rsp_data !== 32'h0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
         bad++;
         $display("FAIL reset rsp regs: got %h %b %b want 0 0 0", rsp_data, rsp_id, rsp_err);
      end
      total++;
      if (pau_op !== 2'b00 || pau_a !== 32'h0 || pau_b !== 32'h0) begin
         bad++;
         $display("FAIL reset pau regs: got %b %h %h want 00 0 0", pau_op, pau_a, pau_b);
      end
      req_valid = 2'b00;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_add();
      stub_mode = 0; stub_fixed = 32'h48000000; stub_delay = 6; stub_never = 1'b0;
      issue(1'b0, 2'b00, 32'h40000000, 32'h40000000, 32'h48000000, 1'b0);
      wait_rsp("single_add", RspLimit);
      total++;
      if (last_run_len !== 6) begin
         bad++; $display("FAIL single_add run_len: got %0d want 6", last_run_len);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      exp_t e;
      stub_mode = 2; stub_delay = 5; stub_never = 1'b0;
      rst = 1'b1;
      req0_op = 2'b10; req0_a = 32'h11110000; req0_b = 32'h0000aaaa;
      req1_op = 2'b11; req1_a = 32'h22220000; req1_b = 32'h00005555;
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         e.id = i[0];
         e.op = i[0] ? 2'b11 : 2'b10;
         e.a = i[0] ? 32'h22220000 : 32'h11110000;
         e.b = i[0] ? 32'h00005555 : 32'h0000aaaa;
         e.data = e.a ^ e.b;
         e.err = 1'b0;
         sb.push_back(e);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_rsp("back_to_back", RspLimit);
      end
      req_valid = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_done_qualify();
      stub_mode = 1; stub_delay = 1; stub_never = 1'b0;
      issue(1'b1, 2'b01, 32'h3333_0000, 32'h0000_4444, 32'h105, 1'b0);
      wait_rsp("done_qualify", RspLimit);
      total++;
      if (last_run_len !== 5) begin
         bad++; $display("FAIL done_qualify run_len: got %0d want 5", last_run_len);
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      stub_never = 1'b1; stub_mode = 2;
      issue(1'b0, 2'b11, 32'h5555_5555, 32'h0f0f_0f0f, 32'h0, 1'b1);
      wait_rsp("timeout", RspLimit);
      total++;
      if (last_run_len !== 256) begin
         bad++; $display("FAIL timeout run_len: got %0d want 256", last_run_len);
      end
      @(negedge clk);
      stub_never = 1'b0; stub_delay = 5;
      issue(1'b1, 2'b00, 32'h1234_5678, 32'h0000_ffff, 32'h1234_a987, 1'b0);
      wait_rsp("after_timeout", RspLimit);
      @(negedge clk);
   endtask

   task automatic test_rsp_stall();
      stub_mode = 2; stub_delay = 5; stub_never = 1'b0;
      rsp_ready = 1'b0;
      issue(1'b1, 2'b10, 32'hdead_0000, 32'h0000_beef, 32'hdead_beef, 1'b0);
      wait_rsp("stall_first", RspLimit);
      req_valid = 2'b11;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if (rsp_valid !== 1'b1 || rsp_data !== 32'hdead_beef || rsp_id !== 1'b1 ||
             rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold cyc %0d: got v=%b d=%h id=%b e=%b want 1 deadbeef 1 0",
                     i, rsp_valid, rsp_data, rsp_id, rsp_err);
         end
         total++;
         if (req_ready !== 2'b00) begin
            bad++; $display("FAIL stall_req_ready cyc %0d: got %b want 00", i, req_ready);
         end
      end
      rsp_ready = 1'b1;
      req_valid = 2'b00;
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL stall_release: got v=%b busy=%b want 0 0", rsp_valid, busy);
      end
   endtask

   task automatic test_reset_mid_run();
      exp_t e;
      stub_never = 1'b1;
      issue(1'b0, 2'b01, 32'haaaa_aaaa, 32'h5555_5555, 32'h0, 1'b0);
      void'(sb.pop_back());   // this operation is abandoned by the reset
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      total++;
      if (pau_start !== 1'b1 || busy !== 1'b1) begin
         bad++; $display("FAIL midrun_active: got start=%b busy=%b want 1 1", pau_start, busy);
      end
      rst = 1'b1;
      req0_op = 2'b10; req0_a = 32'h0f00_0000; req0_b = 32'h0000_00f0;
      req1_op = 2'b11; req1_a = 32'h7700_0000; req1_b = 32'h0000_0077;
      req_valid = 2'b11;
      #1;
      total++;
      if (pau_start !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 2'b00)
      begin
         bad++;
         $display("FAIL midrun_reset: got start=%b busy=%b v=%b rdy=%b want 0 0 0 00",
                  pau_start, busy, rsp_valid, req_ready);
      end
      @(negedge clk);
      @(negedge clk);
      stub_never = 1'b0; stub_mode = 2; stub_delay = 5;
      rst = 1'b0;
      #1;
      total++;
      if (req_ready !== 2'b01) begin
         bad++; $display("FAIL midrun_tie: got req_ready %b want 01", req_ready);
      end
      e.id = 1'b0; e.op = 2'b10; e.a = 32'h0f00_0000; e.b = 32'h0000_00f0;
      e.data = 32'h0f00_00f0; e.err = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      req_valid = 2'b00;
      wait_rsp("midrun_next", RspLimit);
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_back_to_back();
      test_done_qualify();
      test_timeout();
      test_rsp_stall();
      test_reset_mid_run();
      total++;
      if (sb.size() != 0) begin
         bad++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pau_arbiter.md
PAU_ARBITER -- requirements
Module: pau_arbiter

Interface
REQ-001 Parameter PAU_N, 32, posit word width of operands and result.
REQ-002 Parameter WAIT_MIN, 4, minimum RUN cycles before pau_done is sampled.
REQ-003 Parameter TIMEOUT, 255, RUN cycle count at which the operation aborts; must be > WAIT_MIN and < 2^COUNTER_LEN.
REQ-004 Parameter COUNTER_LEN, 8, wait counter width.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  2  per-requester request valid, bit i = requester i.
REQ-008 req_ready  out  2  per-requester accept; one-hot or zero.
REQ-009 req0_op, req1_op  in  2 each  operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-010 req0_a, req0_b, req1_a, req1_b  in  PAU_N each  operands.
REQ-011 pau_start  out  1  held high while the shared posit unit is evaluating.
REQ-012 pau_op  out  2  captured op code to the datapath mux.
REQ-013 pau_a, pau_b  out  PAU_N each  captured operands.
REQ-014 pau_done  in  1  datapath completion flag.
REQ-015 pau_result  in  PAU_N  datapath result.
REQ-016 rsp_valid  out  1  response available.
REQ-017 rsp_ready  in  1  response consumer ready.
REQ-018 rsp_id  out  1  requester index owning the response.
REQ-019 rsp_data  out  PAU_N  result word.
REQ-020 rsp_err  out  1  operation timed out.
REQ-021 busy  out  1  high in any state other than IDLE.

Function
REQ-022 FSM states IDLE, RUN, RESP; no other states reachable.
REQ-023 IDLE: grant = round-robin among asserted req_valid bits, the requester not granted last wins a tie; a sole requester always wins.
REQ-024 req_ready is combinational, asserted only in IDLE and only for the granted requester; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-025 On transfer: capture op, a, b, id into registers, update last_grant, clear counter, go to RUN next cycle.
REQ-026 RUN: pau_start = 1; counter increments by 1 each cycle, saturating at TIMEOUT.
REQ-027 RUN: pau_done is ignored while counter < WAIT_MIN.
REQ-028 RUN: pau_done with counter >= WAIT_MIN captures pau_result into rsp_data, rsp_err = 0, go to RESP.
REQ-029 RUN: counter == TIMEOUT without qualified done sets rsp_data = 0, rsp_err = 1, go to RESP; qualified done in the same cycle wins (err = 0).
REQ-030 RESP: rsp_valid = 1, pau_start = 0; rsp_data, rsp_id, rsp_err stable until rsp_ready; rsp_valid & rsp_ready returns to IDLE next cycle.
REQ-031 req_ready = 0 in RUN and RESP; requests wait, never dropped by the arbiter.
REQ-032 pau_op, pau_a, pau_b hold captured values from transfer until the next transfer.
REQ-033 Minimum issue-to-issue spacing: transfer cycle, WAIT_MIN+1 RUN cycles, one RESP cycle, one IDLE cycle.

Reset
REQ-034 rst high forces IDLE immediately (asynchronous), pau_start = 0, rsp_valid = 0, busy = 0, req_ready = 0 while rst high.
REQ-035 Reset values: counter 0, last_grant = 1 (requester 0 wins first tie), rsp_data 0, rsp_id 0, rsp_err 0, pau_op 00, pau_a 0, pau_b 0.
REQ-036 Reset during RUN or RESP abandons the operation; no response is produced for it.

Verification
REQ-037 Single add: req0 op 00, a 0x40000000, b 0x40000000, stub done after 6 cycles with 0x48000000 -> rsp_valid, rsp_id 0, rsp_data 0x48000000, rsp_err 0.
REQ-038 Both requesters valid continuously from reset, rsp_ready high -> grants alternate 0,1,0,1 over four operations.
REQ-039 Stub asserts pau_done at RUN cycle 1 and holds -> result captured only at counter 4 (WAIT_MIN), not earlier.
REQ-040 Stub never asserts done -> after 255 RUN cycles rsp_err 1, rsp_data 0x00000000, next request then accepted.
REQ-041 rsp_ready low 10 cycles in RESP -> rsp_valid, rsp_data, rsp_id stable; req_ready stays 0 throughout.
REQ-042 rst pulsed mid-RUN -> pau_start and busy drop in the same cycle, no rsp_valid, req0 wins the next tie.
